dsp_delay_line: RTL and testbench

Parametrised, clock-enabled pipeline delay line for the DSP datapath. It generalises the single register-plus-bypass stage to a chain of up to `DEPTH` stages with a run-time latency select, a valid bit carried alongside the data, a synchronous flush, and an occupancy count. Operand paths use it to balance latency between branches, for example when pre-adder and multiplier inputs must align, without a dedicated module for every depth.

---
 rtl/dsp_delay_line_if.sv | 28 ++
 rtl/dsp_delay_line.sv | 94 +++++++++
 tb/tb_dsp_delay_line.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_delay_line_if.sv
// Streaming sample bus of the delay line.
//   in_valid  : qualifier for in_data (driven by the producer)
//   in_data   : input sample
//   out_valid : valid bit at the selected tap (driven by the delay line)
//   out_data  : data at the selected tap
// master : the producer/consumer side; slave : the delay line itself.
interface dsp_delay_line_if #(
    parameter int unsigned WIDTH = 18
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/dsp_delay_line.sv
// Clock-enabled pipeline delay line with run-time latency select.
// A chain of DEPTH stages carries data and a valid bit; the output tap is
// chosen by lat (0 = combinational bypass). Used to balance latency between
// DSP operand branches.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears all state
//   ce      : clock enable, stages shift only when high
//   flush   : synchronous clear of every stage (wins over ce)
//   lat     : selected latency 0..DEPTH; larger values clamp to DEPTH
//   bus     : in_valid/in_data sample in, out_valid/out_data tap out
//   pending : number of valid entries in stages 0..lat-1
//   lat_err : sticky flag, an out-of-range lat was sampled
module dsp_delay_line #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            flush,
    input  logic [LW-1:0]   lat,
    dsp_delay_line_if.slave bus,
    output logic [LW-1:0]   pending,
    output logic            lat_err
);

    localparam logic [LW-1:0] DepthLw = LW'(DEPTH);

    logic [WIDTH-1:0] stg_data_q [DEPTH];
    logic [WIDTH-1:0] stg_data_d [DEPTH];
    logic [DEPTH-1:0] stg_valid_q;
    logic [DEPTH-1:0] stg_valid_d;
    logic             lat_err_q;
    logic             lat_err_d;
    logic [LW-1:0]    lat_eff;

    // Next-state: flush dominates, then shift on ce, otherwise hold.
    always_comb begin
        stg_data_d  = stg_data_q;
        stg_valid_d = stg_valid_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_data_d[i] = '0;
            end
            stg_valid_d = '0;
        end else if (ce) begin
            stg_data_d[0]  = bus.in_data;
            stg_valid_d[0] = bus.in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stg_data_d[i]  = stg_data_q[i-1];
                stg_valid_d[i] = stg_valid_q[i-1];
            end
        end
        // Sampled every edge regardless of ce; only reset clears it.
        lat_err_d = lat_err_q | (lat > DepthLw);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_data_q[i] <= '0;
            end
            stg_valid_q <= '0;
            lat_err_q   <= 1'b0;
        end else begin
            stg_data_q  <= stg_data_d;
            stg_valid_q <= stg_valid_d;
            lat_err_q   <= lat_err_d;
        end
    end

    // Tap select and occupancy. lat=0 falls through to the bypass defaults
    // and counts nothing.
    always_comb begin
        lat_eff       = (lat > DepthLw) ? DepthLw : lat;
        bus.out_valid = bus.in_valid;
        bus.out_data  = bus.in_data;
        pending       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lat_eff == LW'(i + 1)) begin
                bus.out_valid = stg_valid_q[i];
                bus.out_data  = stg_data_q[i];
            end
            if (LW'(i) < lat_eff) begin
                pending = pending + LW'(stg_valid_q[i]);
            end
        end
    end

    assign lat_err = lat_err_q;

endmodule

// File: tb/tb_dsp_delay_line.sv
module tb_dsp_delay_line;

    localparam int unsigned WIDTH = 18;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          flush;
    logic [LW-1:0] lat;
    logic [LW-1:0] pending;
    logic          lat_err;

    dsp_delay_line_if #(.WIDTH(WIDTH)) bus ();

    dsp_delay_line #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .flush  (flush),
        .lat    (lat),
        .bus    (bus),
        .pending(pending),
        .lat_err(lat_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb_q [$];
    logic shifted = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whether the last edge moved the pipe; a held output is not a new beat.
    always @(posedge clk) shifted = rst_n && ce && !flush;

    // Scoreboard monitor: every fresh valid output must be the oldest
    // outstanding beat.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && (lat == 0 || shifted)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got 0x%0h, expected no beat (t=%0t)",
                         bus.out_data, $time);
            end else begin
                check("sb_data", 32'(bus.out_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue(input logic v, input logic [WIDTH-1:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        if (v && ce && !flush && rst_n) sb_q.push_back(d);
    endtask

    // Empty the pipe, then switch latency while nothing is in flight.
    task automatic flush_pipe(input logic [LW-1:0] l);
        tick();
        flush = 1'b1;
        issue(1'b0, '0);
        tick();
        flush = 1'b0;
        sb_q.delete();
        lat = l;
    endtask

    // Stream 1..6 at lat=lsel; window n must show value n-leff.
    task automatic run_sweep(input logic [LW-1:0] lsel, input int leff);
        flush_pipe(lsel);
        for (int n = 1; n <= 6; n++) begin
            tick();
            issue(1'b1, WIDTH'(n));
            sample();
            if (n > leff) begin
                check($sformatf("sweep_valid_l%0d_n%0d", lsel, n), 32'(bus.out_valid), 32'd1);
                check($sformatf("sweep_data_l%0d_n%0d", lsel, n), 32'(bus.out_data),
                      32'(n - leff));
            end else begin
                check($sformatf("sweep_idle_l%0d_n%0d", lsel, n), 32'(bus.out_valid), 32'd0);
            end
        end
        tick();
        issue(1'b0, '0);
        repeat (leff) tick();
    endtask

    logic [3:0] bub_pat;
    int         bub_pend [5];

    initial begin
        rst_n = 1'b0;
        ce    = 1'b1;
        flush = 1'b0;
        lat   = LW'(3);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset held with inputs toggling.
        for (int k = 0; k < 3; k++) begin
            tick();
            issue(k[0], WIDTH'(18'h2AA + k));
            sample();
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_out_data", 32'(bus.out_data), 32'd0);
            check("rst_pending", 32'(pending), 32'd0);
        end
        check("rst_lat_err", 32'(lat_err), 32'd0);

        // First beat after release appears exactly 3 edges later.
        tick();
        rst_n = 1'b1;
        issue(1'b1, 18'h0A1);
        sample();
        check("rel_w0_valid", 32'(bus.out_valid), 32'd0);
        tick();
        issue(1'b0, '0);
        sample();
        check("rel_w1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        sample();
        check("rel_w2_valid", 32'(bus.out_valid), 32'd0);
        tick();
        sample();
        check("rel_w3_valid", 32'(bus.out_valid), 32'd1);
        check("rel_w3_data", 32'(bus.out_data), 32'h0A1);

        // Latency sweep 0..DEPTH.
        for (int l = 0; l <= DEPTH; l++) run_sweep(LW'(l), l);

        // Stall: 0x11 at lat=2 across 5 ce=0 edges.
        flush_pipe(LW'(2));
        tick();
        issue(1'b1, 18'h11);
        tick();
        ce = 1'b0;
        issue(1'b0, '0);
        sample();
        check("stall_w1_valid", 32'(bus.out_valid), 32'd0);
        check("stall_w1_pending", 32'(pending), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            sample();
            check("stall_frozen_valid", 32'(bus.out_valid), 32'd0);
            check("stall_frozen_pending", 32'(pending), 32'd1);
        end
        ce = 1'b1;
        tick();
        sample();
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_out_data", 32'(bus.out_data), 32'h11);
        check("stall_out_pending", 32'(pending), 32'd1);

        // Bubbles: pattern 1,0,1,1 at lat=4.
        bub_pat  = 4'b1101;  // bit k = beat k
        bub_pend = '{0, 1, 1, 2, 3};
        flush_pipe(LW'(4));
        for (int w = 0; w < 8; w++) begin
            tick();
            if (w < 4) issue(bub_pat[w], WIDTH'(18'h21 + w));
            else issue(1'b0, '0);
            sample();
            if (w <= 4) check($sformatf("bub_pending_w%0d", w), 32'(pending),
                              32'(bub_pend[w]));
            if (w >= 4) check($sformatf("bub_valid_w%0d", w), 32'(bus.out_valid),
                              32'(bub_pat[w-4]));
        end

        // Flush with ce while the pipe is full at lat=3.
        flush_pipe(LW'(3));
        for (int k = 0; k < 4; k++) begin
            tick();
            issue(1'b1, WIDTH'(18'h31 + k));
        end
        tick();
        flush = 1'b1;
        issue(1'b1, 18'h3FF);
        sample();
        check("flush_pre_pending", 32'(pending), 32'd3);
        tick();
        flush = 1'b0;
        sb_q.delete();
        issue(1'b0, '0);
        sample();
        check("flush_pending", 32'(pending), 32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            sample();
            check("flush_no_3ff", 32'(bus.out_valid), 32'd0);
        end

        // Bad latency: lat=5 clamps to 4, lat_err sticky through flush.
        flush_pipe(LW'(4));
        tick();
        lat = LW'(5);
        sample();
        check("bad_lat_err_before", 32'(lat_err), 32'd0);
        tick();
        sample();
        check("bad_lat_err_after", 32'(lat_err), 32'd1);
        run_sweep(LW'(5), 4);
        flush_pipe(LW'(2));
        sample();
        check("bad_lat_err_flush", 32'(lat_err), 32'd1);

        // Mid-stream reset clears lat_err and all state immediately.
        tick();
        rst_n = 1'b0;
        issue(1'b1, 18'h155);
        sb_q.delete();
        #1;
        check("rst2_lat_err", 32'(lat_err), 32'd0);
        check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst2_out_data", 32'(bus.out_data), 32'd0);
        check("rst2_pending", 32'(pending), 32'd0);
        tick();
        rst_n = 1'b1;
        issue(1'b0, '0);
        tick();
        sample();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
